// File: rtl/seven_pkg.sv
// Shared constants for the 7-segment capture path: anode codes, active-low glyphs,
// default stability threshold and the frame FSM state type.
package seven_pkg;

  localparam int STABLE_CYCLES_DEF = 1;

  localparam logic [3:0] AN_D0    = 4'b1110;
  localparam logic [3:0] AN_D1    = 4'b1101;
  localparam logic [3:0] AN_D2    = 4'b1011;
  localparam logic [3:0] AN_D3    = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  // Active-low, bit0 = segment a ... bit6 = segment g
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic {ST_HUNT, ST_COLLECT} state_t;

endpackage

// File: rtl/seven_decode.sv
// Combinational glyph-to-nibble decoder; anything outside the 16 hex glyphs is invalid.
module seven_decode
  import seven_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       valid
);

  always_comb begin
    nib   = 4'h0;
    valid = 1'b1;
    case (seg)
      SEG_0: nib = 4'h0;
      SEG_1: nib = 4'h1;
      SEG_2: nib = 4'h2;
      SEG_3: nib = 4'h3;
      SEG_4: nib = 4'h4;
      SEG_5: nib = 4'h5;
      SEG_6: nib = 4'h6;
      SEG_7: nib = 4'h7;
      SEG_8: nib = 4'h8;
      SEG_9: nib = 4'h9;
      SEG_A: nib = 4'hA;
      SEG_B: nib = 4'hB;
      SEG_C: nib = 4'hC;
      SEG_D: nib = 4'hD;
      SEG_E: nib = 4'hE;
      SEG_F: nib = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_capture.sv
// Samples a scanned 7-segment bus and reassembles {d3,d2,d1,d0} into big_bin.
// Optional SEVEN_CAPTURE_CHANGE_EN: frame_valid only when the published value changes.
module seven_capture
  import seven_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [6:0]  seven,
  output logic [15:0] big_bin,
  output logic        frame_valid,
  output logic        frame_err
);

  logic [3:0]  an_q;
  logic [6:0]  seven_q;
  logic [7:0]  cnt;
  logic        acc_lat;
  logic        changed, stable, is_digit, bad_an, accept, an_err;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        g_valid;

  state_t      state, state_n;
  logic [1:0]  expected, exp_n;
  logic [11:0] shadow, shadow_n;
  logic        publish, err, pulse;

  assign changed = {AN, seven} != {an_q, seven_q};
  // cnt counts repeats beyond the first sample, so the pair has been seen cnt+1 times
  assign stable  = (32'(cnt) + 32'd1) >= 32'(STABLE_CYCLES);

  always_comb begin
    is_digit = 1'b1;
    bad_an   = 1'b0;
    idx      = 2'd0;
    case (an_q)
      AN_D0:    idx = 2'd0;
      AN_D1:    idx = 2'd1;
      AN_D2:    idx = 2'd2;
      AN_D3:    idx = 2'd3;
      AN_BLANK: is_digit = 1'b0;
      default: begin
        is_digit = 1'b0;
        bad_an   = 1'b1;
      end
    endcase
  end

  assign accept = is_digit && stable && !acc_lat;
  assign an_err = bad_an && !acc_lat;

  seven_decode u_dec (
    .seg   (seven_q),
    .nib   (nib),
    .valid (g_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= AN_BLANK;
      seven_q <= 7'h7F;
      cnt     <= 8'd0;
      acc_lat <= 1'b0;
    end else begin
      an_q    <= AN;
      seven_q <= seven;
      cnt     <= changed ? 8'd0 : ((cnt == 8'hFF) ? cnt : cnt + 8'd1);
      acc_lat <= changed ? 1'b0 : (acc_lat | accept | an_err);
    end
  end

  always_comb begin
    state_n  = state;
    exp_n    = expected;
    shadow_n = shadow;
    publish  = 1'b0;
    err      = 1'b0;
    if (an_err) begin
      err     = 1'b1;
      state_n = ST_HUNT;
    end else if (accept) begin
      if (!g_valid) begin
        err     = 1'b1;
        state_n = ST_HUNT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (idx == 2'd0) begin
              shadow_n[3:0] = nib;
              state_n       = ST_COLLECT;
              exp_n         = 2'd1;
            end
          end
          ST_COLLECT: begin
            if (idx == expected) begin
              if (idx == 2'd3) begin
                publish = 1'b1;
                state_n = ST_HUNT;
              end else begin
                shadow_n[{idx, 2'b00} +: 4] = nib;
                exp_n = expected + 2'd1;
              end
            end else if (idx == 2'd0) begin
              // a fresh digit0 mid-frame restarts collection rather than dropping it
              err           = 1'b1;
              shadow_n[3:0] = nib;
              exp_n         = 2'd1;
            end else begin
              err     = 1'b1;
              state_n = ST_HUNT;
            end
          end
          default: state_n = ST_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HUNT;
      expected <= 2'd0;
      shadow   <= 12'd0;
    end else begin
      state    <= state_n;
      expected <= exp_n;
      shadow   <= shadow_n;
    end
  end

`ifdef SEVEN_CAPTURE_CHANGE_EN
  logic pub_seen;
  assign pulse = publish && (!pub_seen || ({nib, shadow} != big_bin));

  always_ff @(posedge clk) begin
    if (rst)          pub_seen <= 1'b0;
    else if (publish) pub_seen <= 1'b1;
  end
`else
  assign pulse = publish;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      big_bin     <= 16'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (publish) big_bin <= {nib, shadow};
      frame_valid <= pulse;
      frame_err   <= err;
    end
  end

endmodule

// File: tb/tb_seven_capture.sv
// Scoreboard bench: two captures (STABLE_CYCLES 1 and 3) driven with directed scans.
module tb_seven_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an1, an3;
  logic [6:0]  sev1, sev3;
  logic [15:0] bb1, bb3;
  logic        fv1, fv3, fe1, fe3;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {logic [15:0] v; int c;} exp_t;
  exp_t fq0[$], fq1[$];
  int   eq0[$], eq1[$];
  logic [15:0] lastv[2];
  bit          seen[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seven_capture #(.STABLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .AN(an1), .seven(sev1),
    .big_bin(bb1), .frame_valid(fv1), .frame_err(fe1));

  seven_capture #(.STABLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .AN(an3), .seven(sev3),
    .big_bin(bb3), .frame_valid(fv3), .frame_err(fe3));

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] anode(input int i);
    logic [3:0] a;
    a = 4'b1111;
    a[i] = 1'b0;
    return a;
  endfunction

  function automatic int sc(input int w);
    return (w == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic expect_frame(input int w, input logic [15:0] v, input int c);
    exp_t e;
    bit   push;
    e.v = v;
    e.c = c;
    push = 1'b1;
`ifdef SEVEN_CAPTURE_CHANGE_EN
    if (seen[w] && lastv[w] == v) push = 1'b0;
`endif
    if (push) begin
      if (w == 0) fq0.push_back(e);
      else        fq1.push_back(e);
    end
    lastv[w] = v;
    seen[w]  = 1'b1;
  endtask

  task automatic expect_err(input int w, input int c);
    if (w == 0) eq0.push_back(c);
    else        eq1.push_back(c);
  endtask

  task automatic put(input int w, input logic [3:0] a, input logic [6:0] s,
                     input int dwell, output int c);
    if (w == 0) begin an1 = a; sev1 = s; end
    else        begin an3 = a; sev3 = s; end
    c = cyc;
    repeat (dwell) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int w, input logic [15:0] v, input int dwell, input bit pub);
    int c;
    for (int i = 0; i < 4; i++) put(w, anode(i), glyph(v[i*4 +: 4]), dwell, c);
    if (pub) expect_frame(w, v, c + 1 + sc(w));
  endtask

  task automatic mon(input int w, input logic fv, input logic fe, input logic [15:0] bb);
    exp_t e;
    int   ec;
    bit   empty;
    if (fv) begin
      checks++;
      empty = (w == 0) ? (fq0.size() == 0) : (fq1.size() == 0);
      if (empty) begin
        fails++;
        $display("FAIL frame_valid_unexpected dut%0d cyc=%0d got=%h want=none", w, cyc, bb);
      end else begin
        if (w == 0) e = fq0.pop_front();
        else        e = fq1.pop_front();
        if (bb !== e.v || cyc != e.c) begin
          fails++;
          $display("FAIL frame dut%0d got=%h@%0d want=%h@%0d", w, bb, cyc, e.v, e.c);
        end
      end
    end
    if (fe) begin
      checks++;
      empty = (w == 0) ? (eq0.size() == 0) : (eq1.size() == 0);
      if (empty) begin
        fails++;
        $display("FAIL frame_err_unexpected dut%0d cyc=%0d got=1 want=0", w, cyc);
      end else begin
        if (w == 0) ec = eq0.pop_front();
        else        ec = eq1.pop_front();
        if (cyc != ec) begin
          fails++;
          $display("FAIL frame_err_timing dut%0d got=%0d want=%0d", w, cyc, ec);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, fv1, fe1, bb1);
    mon(1, fv3, fe3, bb3);
  end

  initial begin
    int c;
    rst = 1'b1;
    an1 = 4'hF; sev1 = 7'h7F;
    an3 = 4'hF; sev3 = 7'h7F;
    lastv[0] = 16'h0; lastv[1] = 16'h0;
    seen[0] = 1'b0;   seen[1] = 1'b0;
    @(posedge clk); #1;
    chk("reset_big_bin1", bb1, 16'h0);
    chk("reset_fv1", {15'h0, fv1}, 16'h0);
    chk("reset_fe1", {15'h0, fe1}, 16'h0);
    chk("reset_big_bin3", bb3, 16'h0);
    chk("reset_fv3", {15'h0, fv3}, 16'h0);
    chk("reset_fe3", {15'h0, fe3}, 16'h0);
    rst = 1'b0;
    put(0, 4'hF, 7'h7F, 2, c);

    // full-rate loopback of BEEF
    repeat (5) scan(0, 16'hBEEF, 1, 1'b1);
    put(0, 4'hF, 7'h7F, 2, c);
    chk("loopback_big_bin", bb1, lastv[0]);

    // good frame, then out-of-order 0,1,3
    scan(0, 16'h1234, 1, 1'b1);
    put(0, 4'hF, 7'h7F, 2, c);
    put(0, anode(0), glyph(4'h1), 1, c);
    put(0, anode(1), glyph(4'h2), 1, c);
    put(0, anode(3), glyph(4'h4), 1, c);
    expect_err(0, c + 2);
    put(0, 4'hF, 7'h7F, 2, c);
    chk("order_err_hold", bb1, 16'h1234);

    // illegal anode code mid-frame
    put(0, anode(0), glyph(4'h9), 1, c);
    put(0, anode(1), glyph(4'h8), 1, c);
    put(0, 4'b1100, glyph(4'h0), 1, c);
    expect_err(0, c + 2);
    put(0, anode(2), glyph(4'h7), 1, c);
    put(0, anode(3), glyph(4'h6), 1, c);
    put(0, 4'hF, 7'h7F, 2, c);
    chk("bad_anode_hold", bb1, 16'h1234);

    // all-off glyph on digit1, then a clean ABCD
    put(0, anode(0), glyph(4'hD), 1, c);
    put(0, anode(1), 7'h7F, 1, c);
    expect_err(0, c + 2);
    put(0, anode(2), glyph(4'hB), 1, c);
    put(0, anode(3), glyph(4'hA), 1, c);
    put(0, 4'hF, 7'h7F, 2, c);
    chk("bad_glyph_hold", bb1, 16'h1234);
    scan(0, 16'hABCD, 1, 1'b1);
    put(0, 4'hF, 7'h7F, 2, c);
    chk("abcd_big_bin", bb1, 16'hABCD);

    // reset after digits 0 and 1
    put(0, anode(0), glyph(4'h8), 1, c);
    put(0, anode(1), glyph(4'h7), 1, c);
    rst = 1'b1;
    an1 = 4'hF; sev1 = 7'h7F;
    @(posedge clk); #1;
    rst = 1'b0;
    lastv[0] = 16'h0; lastv[1] = 16'h0;
    seen[0] = 1'b0;   seen[1] = 1'b0;
    chk("midreset_big_bin", bb1, 16'h0);
    chk("midreset_fv", {15'h0, fv1}, 16'h0);
    chk("midreset_fe", {15'h0, fe1}, 16'h0);
    put(0, 4'hF, 7'h7F, 2, c);
    scan(0, 16'h5678, 1, 1'b1);
    put(0, 4'hF, 7'h7F, 2, c);
    chk("post_reset_big_bin", bb1, 16'h5678);

    // stability filter on the STABLE_CYCLES=3 instance
    scan(1, 16'h1234, 2, 1'b0);
    scan(1, 16'h1234, 2, 1'b0);
    put(1, 4'hF, 7'h7F, 4, c);
    chk("short_dwell_big_bin", bb3, 16'h0);
    scan(1, 16'h1234, 3, 1'b1);
    scan(1, 16'h1234, 4, 1'b1);
    put(1, 4'hF, 7'h7F, 6, c);
    chk("long_dwell_big_bin", bb3, 16'h1234);
    chk("dut1_undisturbed", bb1, 16'h5678);

    checks++;
    if (fq0.size() != 0 || eq0.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses dut0 got=%0d/%0d want=0/0", fq0.size(), eq0.size());
    end
    checks++;
    if (fq1.size() != 0 || eq1.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses dut1 got=%0d/%0d want=0/0", fq1.size(), eq1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
